// File: rtl/video_pkg.sv
// Shared pixel types, widths and helpers for the VGA output path.
package video_pkg;

  localparam int unsigned RGB_W = 6;
  localparam int unsigned CH_W  = 2;

  // One pixel, 2 bits per channel, packed MSB-first as RRGGBB.
  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    HIDDEN   = 2'd0,
    FADE_IN  = 2'd1,
    SHOWN    = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_t;

  // Limit one overlay channel to the current fade level.
  function automatic logic [CH_W-1:0] ch_clamp(input logic [CH_W-1:0] ch,
                                               input logic [CH_W-1:0] level);
    return (ch < level) ? ch : level;
  endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// Registered one-cycle frame tick on each falling edge of active-low vsync.
module vsync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic frame_tick
);

  logic vsync_q;
  logic armed;

  // vsync_q resets high; armed masks the first post-reset cycle so a vsync
  // held low through reset is not mistaken for a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b1;
      armed      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      armed      <= 1'b1;
      frame_tick <= armed & vsync_q & ~vsync;
    end
  end

endmodule

// File: rtl/overlay_compositor.sv
// Final pixel stage: merges the text overlay onto the background with a
// per-frame fade-in / hold / fade-out / hide cycle and registers the result.
module overlay_compositor
  import video_pkg::*;
#(
  parameter int unsigned HIDE_FRAMES = 60,
  parameter int unsigned STEP_FRAMES = 8,
  parameter int unsigned SHOW_FRAMES = 120
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RGB_W-1:0] bg_rgb,
  input  logic [RGB_W-1:0] overlay_rgb,
  input  logic             overlay_active,
  input  logic             frame_active,
  input  logic             vsync,
  input  logic             enable,
  output logic [RGB_W-1:0] rgb_out,
  output logic [CH_W-1:0]  fade_level,
  output logic             overlay_shown
);

  localparam int unsigned MAX_HS  = (HIDE_FRAMES > SHOW_FRAMES) ? HIDE_FRAMES : SHOW_FRAMES;
  localparam int unsigned CNT_MAX = (STEP_FRAMES > MAX_HS) ? STEP_FRAMES : MAX_HS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HIDE_LAST = CNT_W'(HIDE_FRAMES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_FRAMES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_FRAMES - 1);
  localparam logic [CH_W-1:0]  LEVEL_MAX = CH_W'(3);

  logic              frame_tick;
  fade_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   level_d;
  rgb_t              ov;
  rgb_t              ov_c;
  logic [RGB_W-1:0]  pix_c;

  vsync_edge_detect u_vsync_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  // FSM state, frame counter, fade level and shown flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HIDDEN;
      cnt_q         <= '0;
      fade_level    <= '0;
      overlay_shown <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fade_level    <= level_d;
      overlay_shown <= (level_d != '0);
    end
  end

  // Next state: enable low forces full overlay; otherwise advance on frame ticks only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = fade_level;
    if (!enable) begin
      state_d = SHOWN;
      cnt_d   = '0;
      level_d = LEVEL_MAX;
    end else if (frame_tick) begin
      case (state_q)
        HIDDEN: begin
          level_d = '0;
          if (cnt_q == HIDE_LAST) begin
            state_d = FADE_IN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FADE_IN: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d   = '0;
            level_d = fade_level + CH_W'(1);
            if (fade_level == LEVEL_MAX - CH_W'(1)) state_d = SHOWN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SHOWN: begin
          level_d = LEVEL_MAX;
          if (cnt_q == SHOW_LAST) begin
            state_d = FADE_OUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FADE_OUT: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d   = '0;
            level_d = fade_level - CH_W'(1);
            if (fade_level == CH_W'(1)) state_d = HIDDEN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = HIDDEN;
          cnt_d   = '0;
          level_d = '0;
        end
      endcase
    end
  end

  assign ov = rgb_t'(overlay_rgb);

  // Per-channel clamp of the overlay, then select blank / overlay / background.
  always_comb begin
    ov_c.r = ch_clamp(ov.r, fade_level);
    ov_c.g = ch_clamp(ov.g, fade_level);
    ov_c.b = ch_clamp(ov.b, fade_level);
    pix_c  = '0;
    if (frame_active) begin
      if (overlay_active && (fade_level != '0)) pix_c = ov_c;
      else                                      pix_c = bg_rgb;
    end
  end

  // Output pixel register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_out <= '0;
    else        rgb_out <= pix_c;
  end

endmodule

// File: tb/tb_overlay_compositor.sv
// Self-checking bench for overlay_compositor (HIDE=2, STEP=1, SHOW=3).
module tb_overlay_compositor;

  logic       clk;
  logic       rst_n;
  logic [5:0] bg_rgb;
  logic [5:0] overlay_rgb;
  logic       overlay_active;
  logic       frame_active;
  logic       vsync;
  logic       enable;
  logic [5:0] rgb_out;
  logic [1:0] fade_level;
  logic       overlay_shown;

  int n_checks;
  int n_fail;
  logic [5:0] exp_q[$];

  overlay_compositor #(
    .HIDE_FRAMES (2),
    .STEP_FRAMES (1),
    .SHOW_FRAMES (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bg_rgb         (bg_rgb),
    .overlay_rgb    (overlay_rgb),
    .overlay_active (overlay_active),
    .frame_active   (frame_active),
    .vsync          (vsync),
    .enable         (enable),
    .rgb_out        (rgb_out),
    .fade_level     (fade_level),
    .overlay_shown  (overlay_shown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // Reference compositing for one pixel at a given fade level.
  function automatic logic [5:0] model_pix(input logic [5:0] bg, input logic [5:0] ov,
                                           input logic act, input logic fa,
                                           input logic [1:0] lvl);
    logic [5:0] r;
    logic [1:0] c;
    if (!fa) return 6'b0;
    if (!act || lvl == 2'd0) return bg;
    for (int k = 0; k < 3; k++) begin
      c = ov[2*k +: 2];
      r[2*k +: 2] = (c > lvl) ? lvl : c;
    end
    return r;
  endfunction

  // Drive one pixel (call at a negedge) and queue its expected output.
  task automatic send_pix(input logic [5:0] bg, input logic [5:0] ov, input logic act,
                          input logic fa, input logic [1:0] lvl);
    bg_rgb = bg; overlay_rgb = ov; overlay_active = act; frame_active = fa;
    exp_q.push_back(model_pix(bg, ov, act, fa, lvl));
  endtask

  // One vsync low pulse; returns at the negedge after the tick has been applied.
  task automatic pulse_vsync(input logic drop_en);
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    if (drop_en) enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bg_rgb = 6'($urandom); overlay_rgb = 6'($urandom);
      overlay_active = 1'b1; frame_active = 1'b1;
    end
    n_checks++;
    if (rgb_out !== 6'b0) begin
      n_fail++; $display("FAIL reset_rgb: got %b expected %b", rgb_out, 6'b0);
    end
    n_checks++;
    if (fade_level !== 2'd0 || overlay_shown !== 1'b0) begin
      n_fail++; $display("FAIL reset_level: got %0d/%b expected 0/0", fade_level, overlay_shown);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (fade_level !== 2'd0) begin
      n_fail++; $display("FAIL reset_release_level: got %0d expected 0", fade_level);
    end
    vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hidden();
    logic [5:0] e;
    send_pix(6'b00_01_10, 6'b11_11_11, 1'b1, 1'b1, 2'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (rgb_out !== e || e !== 6'b00_01_10) begin
      n_fail++; $display("FAIL hidden_pix: got %b expected %b", rgb_out, 6'b00_01_10);
    end
  endtask

  task automatic test_fade_sequence();
    logic [1:0] exp_lv [11];
    logic [5:0] e;
    exp_lv = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 11; i++) begin
      pulse_vsync(1'b0);
      n_checks++;
      if (fade_level !== exp_lv[i] || overlay_shown !== (exp_lv[i] != 2'd0)) begin
        n_fail++;
        $display("FAIL fade_tick%0d: got level %0d shown %b expected level %0d", i + 1,
                 fade_level, overlay_shown, exp_lv[i]);
      end
      if (i == 2) begin
        send_pix(6'b10_11_00, 6'b01_01_01, 1'b1, 1'b1, exp_lv[i]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (rgb_out !== e) begin
          n_fail++; $display("FAIL shadow_l1: got %b expected %b", rgb_out, e);
        end
      end
      if (i == 3) begin
        send_pix(6'b00_00_01, 6'b11_11_11, 1'b1, 1'b1, exp_lv[i]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (rgb_out !== e) begin
          n_fail++; $display("FAIL overlay_l2: got %b expected %b", rgb_out, e);
        end
      end
      if (i == 4) begin
        send_pix(6'b10_01_11, 6'b11_10_01, 1'b1, 1'b0, exp_lv[i]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (rgb_out !== e) begin
          n_fail++; $display("FAIL blanking_l3: got %b expected %b", rgb_out, e);
        end
        send_pix(6'b10_01_11, 6'b11_10_01, 1'b0, 1'b1, exp_lv[i]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (rgb_out !== e) begin
          n_fail++; $display("FAIL bg_passthru_l3: got %b expected %b", rgb_out, e);
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [1:0] exp_a [4];
    logic [1:0] exp_b [4];
    exp_a = '{2'd3, 2'd3, 2'd3, 2'd2};
    exp_b = '{2'd3, 2'd3, 2'd3, 2'd2};
    enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fade_level !== 2'd3 || overlay_shown !== 1'b1) begin
      n_fail++; $display("FAIL enable_force: got %0d expected 3", fade_level);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse_vsync(1'b0);
      n_checks++;
      if (fade_level !== exp_a[i]) begin
        n_fail++; $display("FAIL enable_show%0d: got %0d expected %0d", i, fade_level, exp_a[i]);
      end
    end
    pulse_vsync(1'b1);
    n_checks++;
    if (fade_level !== 2'd3) begin
      n_fail++; $display("FAIL enable_drop_tick: got %0d expected 3", fade_level);
    end
    pulse_vsync(1'b0);
    n_checks++;
    if (fade_level !== 2'd3) begin
      n_fail++; $display("FAIL enable_hold: got %0d expected 3", fade_level);
    end
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      pulse_vsync(1'b0);
      n_checks++;
      if (fade_level !== exp_b[i]) begin
        n_fail++; $display("FAIL reenable%0d: got %0d expected %0d", i, fade_level, exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid_fade();
    logic [5:0] e;
    logic [1:0] exp_lv [3];
    exp_lv = '{2'd0, 2'd0, 2'd1};
    send_pix(6'b01_01_01, 6'b11_11_11, 1'b1, 1'b1, 2'd2);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (rgb_out !== e) begin
      n_fail++; $display("FAIL midfade_pix: got %b expected %b", rgb_out, e);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rgb_out !== 6'b0 || fade_level !== 2'd0 || overlay_shown !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b/%0d/%b expected 000000/0/0", rgb_out, fade_level,
               overlay_shown);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse_vsync(1'b0);
      n_checks++;
      if (fade_level !== exp_lv[i]) begin
        n_fail++; $display("FAIL restart_tick%0d: got %0d expected %0d", i + 1, fade_level, exp_lv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    for (int i = 0; i <= 24; i++) begin
      if (i > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rgb_out !== e) begin
          n_fail++; $display("FAIL b2b_pix%0d: got %b expected %b", i - 1, rgb_out, e);
        end
      end
      if (i < 24)
        send_pix(6'($urandom), 6'($urandom), 1'($urandom), (i % 5) != 0, 2'd1);
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; vsync = 1'b0; enable = 1'b1;
    bg_rgb = '0; overlay_rgb = '0; overlay_active = 1'b0; frame_active = 1'b0;
    test_reset();
    test_hidden();
    test_fade_sequence();
    test_enable();
    test_reset_mid_fade();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
